// File: rtl/vend_controller.sv
// Vending controller: collects coins, dispenses products A or B, and returns change one unit at a time.
// All outputs are registered. state_dbg exposes the FSM state (0 idle, 1 collect, 2 vend, 3 change).
module vend_controller #(
    parameter int PRICE_A    = 3,
    parameter int PRICE_B    = 4,
    parameter int MAX_CREDIT = 6,
    parameter int TIMEOUT    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] coin,
    input  logic [1:0] sel,
    input  logic       vend_ack,
    input  logic       chg_ready,
    output logic       vend_req,
    output logic [1:0] vend_id,
    output logic       chg_valid,
    output logic [3:0] credit,
    output logic       coin_reject,
    output logic       sel_nack,
    output logic       busy,
    output logic [1:0] state_dbg
);

    // Dispenser handshake: vend_req/vend_id stay stable until vend_ack is seen high while
    // vend_req is high. Change handshake: one unit moves on every cycle where chg_valid and
    // chg_ready are both high.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_VEND    = 2'd2;
    localparam logic [1:0] S_CHANGE  = 2'd3;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    credit_q, credit_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          vend_req_q, vend_req_d;
    logic [1:0]    vend_id_q, vend_id_d;
    logic          chg_valid_q, chg_valid_d;
    logic          coin_reject_q, coin_reject_d;
    logic          sel_nack_q, sel_nack_d;
    logic          busy_q, busy_d;

    logic          coin_add, cancel, sel_ok, idle_cycle;
    logic [3:0]    price;
    logic [4:0]    coin_sum;

    always_comb begin
        coin_add      = (coin == 2'b01) || (coin == 2'b10);
        cancel        = (coin == 2'b11);
        sel_ok        = (sel == 2'b01) || (sel == 2'b10);
        price         = (sel == 2'b01) ? 4'(PRICE_A) : 4'(PRICE_B);
        coin_sum      = {1'b0, credit_q} + {3'b000, coin};
        idle_cycle    = 1'b0;
        state_d       = state_q;
        credit_d      = credit_q;
        tmr_d         = '0;
        vend_req_d    = vend_req_q;
        vend_id_d     = vend_id_q;
        coin_reject_d = 1'b0;
        sel_nack_d    = 1'b0;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if ((state_q == S_COLLECT) && cancel) begin
                    state_d = (credit_q != 4'd0) ? S_CHANGE : S_IDLE;
                end else if (sel_ok) begin
                    // A selection always wins over a same-cycle coin insert.
                    coin_reject_d = coin_add;
                    if (credit_q < price) begin
                        sel_nack_d = 1'b1;
                    end else if (state_q == S_COLLECT) begin
                        credit_d   = credit_q - price;
                        vend_req_d = 1'b1;
                        vend_id_d  = sel;
                        state_d    = S_VEND;
                    end
                end else if (coin_add) begin
                    if (coin_sum <= 5'(MAX_CREDIT)) begin
                        credit_d = coin_sum[3:0];
                        state_d  = S_COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                        idle_cycle    = 1'b1;
                    end
                end else begin
                    idle_cycle = 1'b1;
                end

                if (idle_cycle && (state_q == S_COLLECT)) begin
                    if (tmr_q == TW'(TIMEOUT - 1)) begin
                        state_d = (credit_q != 4'd0) ? S_CHANGE : S_IDLE;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            S_VEND: begin
                coin_reject_d = coin_add;
                if (vend_ack) begin
                    vend_req_d = 1'b0;
                    vend_id_d  = 2'b00;
                    state_d    = (credit_q != 4'd0) ? S_CHANGE : S_IDLE;
                end
            end
            default: begin
                coin_reject_d = coin_add;
                if (chg_valid_q && chg_ready) begin
                    credit_d = credit_q - 4'd1;
                    if (credit_q == 4'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        busy_d      = (state_d == S_VEND) || (state_d == S_CHANGE);
        chg_valid_d = (state_d == S_CHANGE) && (credit_d != 4'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            tmr_q         <= '0;
            vend_req_q    <= 1'b0;
            vend_id_q     <= 2'b00;
            chg_valid_q   <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_nack_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            tmr_q         <= tmr_d;
            vend_req_q    <= vend_req_d;
            vend_id_q     <= vend_id_d;
            chg_valid_q   <= chg_valid_d;
            coin_reject_q <= coin_reject_d;
            sel_nack_q    <= sel_nack_d;
            busy_q        <= busy_d;
        end
    end

    assign vend_req    = vend_req_q;
    assign vend_id     = vend_id_q;
    assign chg_valid   = chg_valid_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign sel_nack    = sel_nack_q;
    assign busy        = busy_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios against hand-derived constants, then random
// traffic against a transaction-level model of the vending rules.
module tb_vend_controller;

    localparam int PRICE_A    = 3;
    localparam int PRICE_B    = 4;
    localparam int MAX_CREDIT = 6;
    localparam int TIMEOUT    = 20;

    localparam int PH_IDLE    = 0;
    localparam int PH_COLLECT = 1;
    localparam int PH_VEND    = 2;
    localparam int PH_CHANGE  = 3;

    logic       clk;
    logic       rst;
    logic [1:0] coin;
    logic [1:0] sel;
    logic       vend_ack;
    logic       chg_ready;
    logic       vend_req;
    logic [1:0] vend_id;
    logic       chg_valid;
    logic [3:0] credit;
    logic       coin_reject;
    logic       sel_nack;
    logic       busy;
    logic [1:0] state_dbg;

    int n_cmp = 0;
    int n_mis = 0;

    // Model of the machine in behavioural terms.
    int       m_ph;
    int       m_credit;
    int       m_timer;
    bit       m_req;
    bit [1:0] m_id;
    bit       m_rej;
    bit       m_nack;

    vend_controller #(
        .PRICE_A(PRICE_A), .PRICE_B(PRICE_B), .MAX_CREDIT(MAX_CREDIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .coin(coin), .sel(sel), .vend_ack(vend_ack),
        .chg_ready(chg_ready), .vend_req(vend_req), .vend_id(vend_id),
        .chg_valid(chg_valid), .credit(credit), .coin_reject(coin_reject),
        .sel_nack(sel_nack), .busy(busy), .state_dbg(state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_ph = PH_IDLE; m_credit = 0; m_timer = 0;
        m_req = 1'b0; m_id = 2'b00; m_rej = 1'b0; m_nack = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] c, input logic [1:0] s, input logic a, input logic r);
        bit add, ok, was_collect, cleared;
        int val, price;
        add = (c == 2'b01) || (c == 2'b10);
        ok = (s == 2'b01) || (s == 2'b10);
        val = int'(c);
        price = (s == 2'b01) ? PRICE_A : PRICE_B;
        m_rej = 1'b0; m_nack = 1'b0; cleared = 1'b0;
        was_collect = (m_ph == PH_COLLECT);
        if (m_ph == PH_IDLE || m_ph == PH_COLLECT) begin
            if (was_collect && c == 2'b11) begin
                m_ph = (m_credit > 0) ? PH_CHANGE : PH_IDLE;
                cleared = 1'b1;
            end else if (ok) begin
                m_rej = add;
                cleared = 1'b1;
                if (m_credit < price) m_nack = 1'b1;
                else if (was_collect) begin
                    m_credit -= price; m_req = 1'b1; m_id = s; m_ph = PH_VEND;
                end
            end else if (add) begin
                if (m_credit + val <= MAX_CREDIT) begin
                    m_credit += val; m_ph = PH_COLLECT; cleared = 1'b1;
                end else m_rej = 1'b1;
            end
            if (was_collect && !cleared) begin
                m_timer++;
                if (m_timer >= TIMEOUT) m_ph = (m_credit > 0) ? PH_CHANGE : PH_IDLE;
            end
            if (cleared || m_ph != PH_COLLECT) m_timer = 0;
        end else if (m_ph == PH_VEND) begin
            m_rej = add;
            if (a) begin
                m_req = 1'b0; m_id = 2'b00;
                m_ph = (m_credit > 0) ? PH_CHANGE : PH_IDLE;
            end
        end else begin
            m_rej = add;
            if (r && m_credit > 0) begin
                m_credit--;
                if (m_credit == 0) m_ph = PH_IDLE;
            end
        end
    endtask

    // Drive one cycle of inputs (called at edge+1), advance past the next edge, update the model.
    task automatic cyc(input logic [1:0] c, input logic [1:0] s, input logic a, input logic r);
        coin = c; sel = s; vend_ack = a; chg_ready = r;
        @(posedge clk);
        #1;
        model_step(c, s, a, r);
    endtask

    task automatic do_reset();
        coin = 2'b00; sel = 2'b00; vend_ack = 1'b0; chg_ready = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        if (m_ph == PH_COLLECT) cyc(2'b11, 2'b00, 1'b0, 1'b0);
        if (m_ph == PH_VEND) cyc(2'b00, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 20 && m_ph != PH_IDLE; i++) cyc(2'b00, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        do_reset();
        obs = {state_dbg, busy, vend_req, vend_id, chg_valid, credit, coin_reject, sel_nack};
        n_cmp++; if (obs !== 13'd0) begin n_mis++; $display("FAIL reset_outputs: got %h want 0", obs); end
    endtask

    task automatic test_vend_a();
        cyc(2'b10, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (credit !== 4'd2) begin n_mis++; $display("FAIL a_credit2: got %0d want 2", credit); end
        n_cmp++; if (state_dbg !== 2'd1) begin n_mis++; $display("FAIL a_collect: got %0d want 1", state_dbg); end
        cyc(2'b01, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (credit !== 4'd3) begin n_mis++; $display("FAIL a_credit3: got %0d want 3", credit); end
        cyc(2'b00, 2'b01, 1'b0, 1'b0);
        n_cmp++; if ({vend_req, vend_id, credit, busy} !== {1'b1, 2'b01, 4'd0, 1'b1}) begin
            n_mis++; $display("FAIL a_vend: got req=%b id=%b cr=%0d busy=%b want 1 01 0 1", vend_req, vend_id, credit, busy); end
        cyc(2'b00, 2'b00, 1'b0, 1'b0);
        n_cmp++; if ({vend_req, vend_id} !== 3'b101) begin n_mis++; $display("FAIL a_hold: got %b want 101", {vend_req, vend_id}); end
        cyc(2'b00, 2'b00, 1'b1, 1'b0);
        n_cmp++; if ({state_dbg, vend_req, vend_id, chg_valid, busy} !== 7'd0) begin
            n_mis++; $display("FAIL a_done: got st=%0d req=%b id=%b cv=%b busy=%b want all 0", state_dbg, vend_req, vend_id, chg_valid, busy); end
    endtask

    task automatic test_vend_b_change();
        for (int i = 0; i < 3; i++) cyc(2'b10, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (credit !== 4'd6) begin n_mis++; $display("FAIL b_credit6: got %0d want 6", credit); end
        cyc(2'b00, 2'b10, 1'b0, 1'b0);
        n_cmp++; if ({vend_req, vend_id, credit} !== {1'b1, 2'b10, 4'd2}) begin
            n_mis++; $display("FAIL b_vend: got req=%b id=%b cr=%0d want 1 10 2", vend_req, vend_id, credit); end
        cyc(2'b00, 2'b00, 1'b1, 1'b0);
        n_cmp++; if ({state_dbg, chg_valid, credit, vend_req} !== {2'd3, 1'b1, 4'd2, 1'b0}) begin
            n_mis++; $display("FAIL b_change: got st=%0d cv=%b cr=%0d req=%b want 3 1 2 0", state_dbg, chg_valid, credit, vend_req); end
        cyc(2'b00, 2'b00, 1'b0, 1'b1);
        n_cmp++; if ({chg_valid, credit} !== {1'b1, 4'd1}) begin n_mis++; $display("FAIL b_chg1: got cv=%b cr=%0d want 1 1", chg_valid, credit); end
        cyc(2'b00, 2'b00, 1'b0, 1'b1);
        n_cmp++; if ({state_dbg, chg_valid, credit, busy} !== 8'd0) begin
            n_mis++; $display("FAIL b_chg0: got st=%0d cv=%b cr=%0d busy=%b want 0 0 0 0", state_dbg, chg_valid, credit, busy); end
    endtask

    task automatic test_reject_nack();
        for (int i = 0; i < 3; i++) cyc(2'b10, 2'b00, 1'b0, 1'b0);
        cyc(2'b01, 2'b00, 1'b0, 1'b0);
        n_cmp++; if ({coin_reject, credit} !== {1'b1, 4'd6}) begin n_mis++; $display("FAIL rej_full: got rej=%b cr=%0d want 1 6", coin_reject, credit); end
        cyc(2'b00, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (coin_reject !== 1'b0) begin n_mis++; $display("FAIL rej_pulse: got %b want 0", coin_reject); end
        drain();
        cyc(2'b10, 2'b00, 1'b0, 1'b0);
        cyc(2'b00, 2'b01, 1'b0, 1'b0);
        n_cmp++; if ({sel_nack, credit, state_dbg, vend_req} !== {1'b1, 4'd2, 2'd1, 1'b0}) begin
            n_mis++; $display("FAIL nack: got nack=%b cr=%0d st=%0d req=%b want 1 2 1 0", sel_nack, credit, state_dbg, vend_req); end
        cyc(2'b01, 2'b10, 1'b0, 1'b0);
        n_cmp++; if ({sel_nack, coin_reject, credit} !== {1'b1, 1'b1, 4'd2}) begin
            n_mis++; $display("FAIL sel_beats_coin: got nack=%b rej=%b cr=%0d want 1 1 2", sel_nack, coin_reject, credit); end
        cyc(2'b00, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (sel_nack !== 1'b0) begin n_mis++; $display("FAIL nack_pulse: got %b want 0", sel_nack); end
        drain();
    endtask

    task automatic test_cancel();
        cyc(2'b10, 2'b00, 1'b0, 1'b0);
        cyc(2'b01, 2'b00, 1'b0, 1'b0);
        cyc(2'b11, 2'b01, 1'b0, 1'b0);
        n_cmp++; if ({state_dbg, vend_req, sel_nack, chg_valid, credit} !== {2'd3, 1'b0, 1'b0, 1'b1, 4'd3}) begin
            n_mis++; $display("FAIL cancel: got st=%0d req=%b nack=%b cv=%b cr=%0d want 3 0 0 1 3", state_dbg, vend_req, sel_nack, chg_valid, credit); end
        for (int i = 0; i < 4; i++) cyc(2'b00, 2'b00, 1'b0, 1'b0);
        n_cmp++; if ({chg_valid, credit} !== {1'b1, 4'd3}) begin n_mis++; $display("FAIL cancel_stall: got cv=%b cr=%0d want 1 3", chg_valid, credit); end
        for (int i = 2; i >= 0; i--) begin
            cyc(2'b00, 2'b00, 1'b0, 1'b1);
            n_cmp++; if ({chg_valid, credit} !== {(i != 0), 4'(i)}) begin
                n_mis++; $display("FAIL cancel_return: got cv=%b cr=%0d want %b %0d", chg_valid, credit, (i != 0), i); end
        end
        n_cmp++; if (state_dbg !== 2'd0) begin n_mis++; $display("FAIL cancel_idle: got %0d want 0", state_dbg); end
    endtask

    task automatic test_timeout_and_vend_reject();
        cyc(2'b01, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(2'b00, 2'b11, 1'b0, 1'b0);
        n_cmp++; if (state_dbg !== 2'd1) begin n_mis++; $display("FAIL to_early: got %0d want 1", state_dbg); end
        cyc(2'b00, 2'b00, 1'b0, 1'b0);
        n_cmp++; if ({state_dbg, chg_valid, credit} !== {2'd3, 1'b1, 4'd1}) begin
            n_mis++; $display("FAIL to_fire: got st=%0d cv=%b cr=%0d want 3 1 1", state_dbg, chg_valid, credit); end
        cyc(2'b00, 2'b00, 1'b0, 1'b1);
        n_cmp++; if ({state_dbg, chg_valid, credit} !== 7'd0) begin
            n_mis++; $display("FAIL to_refund: got st=%0d cv=%b cr=%0d want 0 0 0", state_dbg, chg_valid, credit); end
        cyc(2'b10, 2'b00, 1'b0, 1'b0);
        cyc(2'b01, 2'b00, 1'b0, 1'b0);
        cyc(2'b00, 2'b01, 1'b0, 1'b0);
        cyc(2'b10, 2'b00, 1'b0, 1'b0);
        n_cmp++; if ({coin_reject, credit, vend_req} !== {1'b1, 4'd0, 1'b1}) begin
            n_mis++; $display("FAIL vend_coin: got rej=%b cr=%0d req=%b want 1 0 1", coin_reject, credit, vend_req); end
        cyc(2'b00, 2'b00, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_vend();
        cyc(2'b10, 2'b00, 1'b0, 1'b0);
        cyc(2'b10, 2'b00, 1'b0, 1'b0);
        cyc(2'b00, 2'b01, 1'b0, 1'b0);
        n_cmp++; if ({vend_req, credit} !== {1'b1, 4'd1}) begin n_mis++; $display("FAIL rv_pre: got req=%b cr=%0d want 1 1", vend_req, credit); end
        #2 rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if ({state_dbg, vend_req, vend_id, credit, busy, chg_valid} !== 11'd0) begin
            n_mis++; $display("FAIL rv_async: got st=%0d req=%b id=%b cr=%0d busy=%b cv=%b want all 0", state_dbg, vend_req, vend_id, credit, busy, chg_valid); end
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        cyc(2'b01, 2'b00, 1'b0, 1'b0);
        n_cmp++; if ({state_dbg, credit} !== {2'd1, 4'd1}) begin n_mis++; $display("FAIL rv_resume: got st=%0d cr=%0d want 1 1", state_dbg, credit); end
        drain();
    endtask

    task automatic test_random(input int cycles, input int coin_pct);
        logic [1:0] c, s;
        logic a, r;
        int shown = 0;
        for (int i = 0; i < cycles; i++) begin
            c = ($urandom_range(0, 99) < coin_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (c == 2'b11 && $urandom_range(0, 2) != 0) c = 2'b00;
            s = ($urandom_range(0, 99) < coin_pct / 2) ? 2'($urandom_range(0, 3)) : 2'b00;
            a = ($urandom_range(0, 99) < 30);
            r = ($urandom_range(0, 99) < 50);
            cyc(c, s, a, r);
            n_cmp++;
            if ({vend_req, vend_id, chg_valid, credit, coin_reject, sel_nack, busy} !==
                {m_req, m_id, (m_ph == PH_CHANGE && m_credit > 0), 4'(m_credit), m_rej, m_nack,
                 (m_ph == PH_VEND || m_ph == PH_CHANGE)}) begin
                n_mis++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_cyc%0d: got req=%b id=%b cv=%b cr=%0d rej=%b nack=%b busy=%b want req=%b id=%b cr=%0d rej=%b nack=%b phase=%0d",
                             i, vend_req, vend_id, chg_valid, credit, coin_reject, sel_nack, busy,
                             m_req, m_id, m_credit, m_rej, m_nack, m_ph);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; coin = 2'b00; sel = 2'b00; vend_ack = 1'b0; chg_ready = 1'b0;
        model_reset();
        test_reset();
        test_vend_a();
        test_vend_b_change();
        test_reject_nack();
        test_cancel();
        test_timeout_and_vend_reject();
        test_reset_mid_vend();
        do_reset();
        test_random(2000, 40);
        test_random(1500, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1000000;
        n_mis++;
        $display("FAIL watchdog: got no finish by 1000000 want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter PRICE_A, default 3, meaning product A price in 5-unit credits.
REQ-002 SHALL have parameter PRICE_B, default 4, meaning product B price in 5-unit credits.
REQ-003 SHALL have parameter MAX_CREDIT, default 6, meaning maximum held credit (units), at most 15.
REQ-004 SHALL have parameter TIMEOUT, default 20, meaning idle cycles in COLLECT before auto-refund, at least 2.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port coin  input  2  00 none, 01 add 1 unit, 10 add 2 units, 11 cancel/refund.
REQ-008 SHALL have port sel  input  2  00 none, 01 product A, 10 product B, 11 ignored.
REQ-009 SHALL have port vend_ack  input  1  dispenser done; valid only while vend_req=1.
REQ-010 SHALL have port chg_ready  input  1  change hopper accepts one unit coin this cycle.
REQ-011 SHALL have port vend_req  output  1  dispense request, held until acknowledged.
REQ-012 SHALL have port vend_id  output  2  product being dispensed (01 A, 10 B), 00 otherwise.
REQ-013 SHALL have port chg_valid  output  1  one unit of change offered this cycle.
REQ-014 SHALL have port credit  output  4  current held credit in units.
REQ-015 SHALL have port coin_reject  output  1  one-cycle pulse: coin not accepted.
REQ-016 SHALL have port sel_nack  output  1  one-cycle pulse: selection refused (insufficient credit).
REQ-017 SHALL have port busy  output  1  high in VEND or CHANGE.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, VEND, CHANGE; all outputs registered.
REQ-019 SHALL sample all inputs on rising clk; effects visible after that edge (1-cycle latency).
REQ-020 SHALL, in IDLE/COLLECT, accept coin 01/10 when credit+value <= MAX_CREDIT: credit += value, state -> COLLECT.
REQ-021 SHALL, when credit+value > MAX_CREDIT, leave credit unchanged and pulse coin_reject.
REQ-022 SHALL, in COLLECT, on valid sel with credit >= price: credit -= price, vend_id = sel, vend_req = 1, state -> VEND.
REQ-023 SHALL, on valid sel with credit < price (any state IDLE/COLLECT), pulse sel_nack with no other change.
REQ-024 SHALL give sel priority over a same-cycle coin 01/10; that coin is rejected (coin_reject pulse).
REQ-025 SHALL treat coin=11 in COLLECT as cancel: state -> CHANGE, overriding any same-cycle sel; in IDLE it is ignored.
REQ-026 SHALL hold vend_req and vend_id stable in VEND until vend_ack=1; then clear both and go to CHANGE if credit>0, else IDLE.
REQ-027 SHALL, in CHANGE, drive chg_valid=1 while credit>0; each cycle with chg_valid and chg_ready decrements credit by 1.
REQ-028 SHALL leave CHANGE for IDLE on the edge credit reaches 0, with chg_valid low from that edge.
REQ-029 SHALL, in VEND or CHANGE, reject every coin 01/10 (coin_reject pulse) and ignore sel, cancel, and timeout.
REQ-030 SHALL run a timeout counter in COLLECT, cleared on entry, on any accepted coin, and on sel_nack; reaching TIMEOUT -> CHANGE.
REQ-031 SHALL ignore vend_ack outside VEND and chg_ready when chg_valid=0.
REQ-032 SHALL drive busy=1 exactly when state is VEND or CHANGE.

Reset
REQ-033 SHALL, on rst=0 at any time including mid-VEND or mid-CHANGE, immediately force state IDLE, credit=0, timeout counter=0, and all outputs 0.
REQ-034 SHALL resume normal operation from the first rising clk edge after rst returns to 1.

Verification
REQ-035 SHALL cover: coin 10, coin 01, sel 01 -> credit 2, 3, then vend_req=1, vend_id=01, credit 0; vend_ack -> IDLE, no chg_valid.
REQ-036 SHALL cover: credit 6 via three coin 10, sel 10 -> vend B, credit 2; ack -> two chg_valid/chg_ready handshakes, credit 2->1->0, IDLE.
REQ-037 SHALL cover: credit 6, coin 01 -> coin_reject pulse, credit stays 6; sel 01 at credit 2 -> sel_nack, credit 2.
REQ-038 SHALL cover: credit 3, coin 11 with sel 01 same cycle -> CHANGE (cancel wins), three units returned; with chg_ready held 0, chg_valid stays 1 and credit stays 3.
REQ-039 SHALL cover: credit 1, no activity for TIMEOUT cycles -> CHANGE, one unit returned; coin during VEND -> coin_reject.
REQ-040 SHALL cover: rst=0 asserted mid-VEND between clock edges -> vend_req=0, credit=0, state IDLE before the next edge.
